// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2, usable in parameter defaults on flows without $clog2.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Request/result bundle for seq_shift_add_multiplier.
// SEQ_MULT_SIGNED_EN adds the signed_mode request qualifier.
interface seq_shift_add_multiplier_if #(
   parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] p;
`ifdef SEQ_MULT_SIGNED_EN
   logic               signed_mode;
`endif

   modport master (
      output start,
      output a,
      output b,
`ifdef SEQ_MULT_SIGNED_EN
      output signed_mode,
`endif
      input  busy,
      input  done,
      input  p
   );

   modport slave (
      input  start,
      input  a,
      input  b,
`ifdef SEQ_MULT_SIGNED_EN
      input  signed_mode,
`endif
      output busy,
      output done,
      output p
   );
endinterface

// File: rtl/mult_cond_negate.sv
// WIDTH-generic conditional two's-complement: dout = neg ? -din : din.
module mult_cond_negate #(
   parameter int WIDTH = 4
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   assign dout = neg ? ((~din) + WIDTH'(1)) : din;
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier, one partial product per clock, start/done handshake.
// Define SEQ_MULT_SIGNED_EN for the optional two's-complement mode (signed_mode port).
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = clog2(WIDTH + 1)
) (
   input logic                      clk,
   input logic                      rst_n,
   seq_shift_add_multiplier_if.slave bus
);

   localparam int PW = 2 * WIDTH;

   state_t            state, state_nxt;
   logic [PW-1:0]     acc, mcand, acc_sum, prod_final, p_q;
   logic [WIDTH-1:0]  mplier, a_mag, b_mag;
   logic [CNT_W-1:0]  cnt;
   logic              accept, last_iter;

   assign accept    = bus.start && (state != CALC);
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign acc_sum   = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
   logic a_neg, b_neg, neg_q;

   assign a_neg = bus.signed_mode & bus.a[WIDTH-1];
   assign b_neg = bus.signed_mode & bus.b[WIDTH-1];

   // The most-negative value negates to itself, which read unsigned is its magnitude.
   mult_cond_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(a_neg), .din(bus.a),   .dout(a_mag));
   mult_cond_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(b_neg), .din(bus.b),   .dout(b_mag));
   mult_cond_negate #(.WIDTH(PW))    u_neg_p (.neg(neg_q), .din(acc_sum), .dout(prod_final));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      neg_q <= 1'b0;
      else if (accept) neg_q <= a_neg ^ b_neg;
   end
`else
   assign a_mag      = bus.a;
   assign b_mag      = bus.b;
   assign prod_final = acc_sum;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (bus.start) state_nxt = CALC;
         CALC: if (last_iter) state_nxt = DONE;
         DONE: state_nxt = bus.start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The WIDTH-th partial product is folded directly into the p load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         p_q    <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a_mag};
         mplier <= b_mag;
         cnt    <= '0;
      end else if (state == CALC) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last_iter) p_q <= prod_final;
      end
   end

   assign bus.busy = (state == CALC);
   assign bus.done = (state == DONE);
   assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench: WIDTH=4 instance for the main sequence, WIDTH=8 for the wide corner.
module tb_seq_shift_add_multiplier;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   overlap_cnt = 0;
   logic [7:0] last_p = 8'd0;

   always #5 clk = ~clk;

   seq_shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
   seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

   seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   always @(negedge clk) begin
      if (bus4.done === 1'b1) done_cnt++;
      if (bus4.busy === 1'b1 && bus4.done === 1'b1) overlap_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int from_lat, output int lat);
      lat = from_lat;
      while (bus4.done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                        input logic sm, input logic [7:0] exp_p);
      int lat;
      @(negedge clk);
      bus4.a = ia;
      bus4.b = ib;
      bus4.start = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
      bus4.signed_mode = sm;
`else
      if (sm) $display("note: %s signed_mode ignored in unsigned build", tag);
`endif
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a = ~ia;
      bus4.b = ~ib;
      check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
      check({tag, "_p_held"}, 32'(bus4.p), 32'(last_p));
      wait_done(1, lat);
      check({tag, "_latency"}, 32'(lat), 32'd5);
      check({tag, "_p"}, 32'(bus4.p), 32'(exp_p));
      last_p = exp_p;
      @(negedge clk);
      check({tag, "_done_width"}, 32'(bus4.done), 32'd0);
   endtask

   initial begin
      int lat, dc;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
`ifdef SEQ_MULT_SIGNED_EN
      bus4.signed_mode = 1'b0;
      bus8.signed_mode = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus4.busy), 32'd0);
      check("rst_done", 32'(bus4.done), 32'd0);
      check("rst_p", 32'(bus4.p), 32'd0);
      rst_n = 1'b1;

      do_op("u9x8",   4'd9,  4'd8,  1'b0, 8'd72);
      do_op("u13x10", 4'd13, 4'd10, 1'b0, 8'd130);
      do_op("u15x15", 4'd15, 4'd15, 1'b0, 8'd225);
      do_op("u0x11",  4'd0,  4'd11, 1'b0, 8'd0);
      repeat (4) @(negedge clk);
      check("zero_hold_p", 32'(bus4.p), 32'd0);
      check("idle_busy", 32'(bus4.busy), 32'd0);

      // Second start while busy must be ignored.
      dc = done_cnt;
      @(negedge clk); bus4.a = 4'd5; bus4.b = 4'd9; bus4.start = 1'b1;
      @(negedge clk); bus4.start = 1'b0;
      @(negedge clk); bus4.a = 4'd3; bus4.b = 4'd12; bus4.start = 1'b1;
      @(negedge clk); bus4.start = 1'b0;
      wait_done(3, lat);
      check("restart_latency", 32'(lat), 32'd5);
      check("restart_p", 32'(bus4.p), 32'd45);
      repeat (8) @(negedge clk);
      #1;
      check("restart_one_done", 32'(done_cnt - dc), 32'd1);

      // start held high: results every WIDTH+1 cycles.
      @(negedge clk); bus4.a = 4'd2; bus4.b = 4'd3; bus4.start = 1'b1;
      wait_done(0, lat);
      check("b2b_first_lat", 32'(lat), 32'd5);
      check("b2b_first_p", 32'(bus4.p), 32'd6);
      @(negedge clk);
      wait_done(1, lat);
      check("b2b_period1", 32'(lat), 32'd5);
      @(negedge clk);
      wait_done(1, lat);
      check("b2b_period2", 32'(lat), 32'd5);
      bus4.start = 1'b0;
      @(negedge clk);
      check("b2b_stop_busy", 32'(bus4.busy), 32'd0);
      check("b2b_p", 32'(bus4.p), 32'd6);

      // Reset mid-CALC aborts without a done.
      @(negedge clk); bus4.a = 4'd11; bus4.b = 4'd2; bus4.start = 1'b1;
      @(negedge clk); bus4.start = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus4.busy), 32'd0);
      check("abort_done", 32'(bus4.done), 32'd0);
      check("abort_p", 32'(bus4.p), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      dc = done_cnt;
      repeat (8) @(negedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt - dc), 32'd0);
      last_p = 8'd0;
      do_op("u11x2", 4'd11, 4'd2, 1'b0, 8'd22);

`ifdef SEQ_MULT_SIGNED_EN
      do_op("s_m7x3",  4'b1001, 4'd3,    1'b1, 8'hEB);
      do_op("s_m8xm8", 4'b1000, 4'b1000, 1'b1, 8'd64);
      do_op("u_9x3",   4'b1001, 4'd3,    1'b0, 8'd27);
`endif

      // WIDTH=8 corner.
      @(negedge clk); bus8.a = 8'd255; bus8.b = 8'd255; bus8.start = 1'b1;
      @(negedge clk); bus8.start = 1'b0;
      lat = 1;
      while (bus8.done !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check("w8_latency", 32'(lat), 32'd9);
      check("w8_p", 32'(bus8.p), 32'd65025);

      check("busy_done_overlap", 32'(overlap_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
